sinc_n_decimator: RTL and testbench

Parametrised successor to the fixed sinc3 decimation filter. It is a CIC (Hogenauer) decimator with build-time order (1..5) and input width, and a runtime-programmable oversampling ratio up to MAX_OSR. It supports a signed multi-bit input (for multi-bit sigma-delta modulators) or an unsigned 1-bit bitstream. It sits directly after a sigma-delta modulator and produces one decimated output sample per osr enabled input samples, flagged by an output strobe.

---
 rtl/sinc_n_decimator.sv | 113 +++++++++++
 tb/tb_sinc_n_decimator.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sinc_n_decimator.sv
// CIC (Hogenauer) decimator: ORDER pipelined integrators running on every enabled
// sample, and an ORDER-stage comb chain evaluated once per decimation window.
module sinc_n_decimator #(
  parameter int ORDER     = 3,
  parameter int IN_WIDTH  = 1,
  parameter int SIGNED_IN = 0,
  parameter int MAX_OSR   = 32,
  parameter int OSR_BITS  = $clog2(MAX_OSR + 1),
  parameter int OUT_WIDTH = IN_WIDTH + ((SIGNED_IN != 0) ? 0 : 1) + ORDER * $clog2(MAX_OSR)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic [OSR_BITS-1:0]  osr,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 outValid
);

  logic [OUT_WIDTH-1:0] w_inExt;
  logic [OSR_BITS-1:0]  w_osrClamped;
  logic [OSR_BITS-1:0]  w_osrEff;
  logic [OSR_BITS-1:0]  r_osrEff;
  logic [OSR_BITS-1:0]  r_count;
  logic                 r_osrArmed;
  logic                 w_strobe;
  logic [OUT_WIDTH-1:0] r_integ   [ORDER];
  logic [OUT_WIDTH-1:0] r_combDly [ORDER];
  logic [OUT_WIDTH-1:0] w_combIn  [ORDER];
  logic [OUT_WIDTH-1:0] w_combOut;

  generate
    if (SIGNED_IN != 0) begin : g_signExt
      assign w_inExt = OUT_WIDTH'($signed(in));
    end else begin : g_zeroExt
      assign w_inExt = OUT_WIDTH'(in);
    end
  endgenerate

  always_comb begin
    w_osrClamped = osr;
    if (osr == '0) begin
      w_osrClamped = OSR_BITS'(1);
    end else if (osr > OSR_BITS'(MAX_OSR)) begin
      w_osrClamped = OSR_BITS'(MAX_OSR);
    end
  end

  // The ratio is captured on the first clock after reset rather than loaded
  // asynchronously from a live port; until then the clamped port value is used.
  assign w_osrEff = r_osrArmed ? r_osrEff : w_osrClamped;
  assign w_strobe = en && (r_count == (w_osrEff - OSR_BITS'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_osrEff   <= OSR_BITS'(1);
      r_osrArmed <= 1'b0;
    end else begin
      r_osrArmed <= 1'b1;
      if (!r_osrArmed) begin
        r_osrEff <= w_osrClamped;
      end
      if (w_strobe) begin
        r_count  <= '0;
        r_osrEff <= w_osrClamped;
      end else if (en) begin
        r_count <= r_count + OSR_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        r_integ[k] <= '0;
      end
    end else if (en) begin
      r_integ[0] <= r_integ[0] + w_inExt;
      for (int k = 1; k < ORDER; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
    end
  end

  // Differential delay of one window: each stage subtracts its previous input.
  always_comb begin
    w_combOut = r_integ[ORDER-1];
    for (int k = 0; k < ORDER; k++) begin
      w_combIn[k] = w_combOut;
      w_combOut   = w_combOut - r_combDly[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) begin
        r_combDly[k] <= '0;
      end
      out      <= '0;
      outValid <= 1'b0;
    end else begin
      outValid <= w_strobe;
      if (w_strobe) begin
        for (int k = 0; k < ORDER; k++) begin
          r_combDly[k] <= w_combIn[k];
        end
        out <= w_combOut;
      end
    end
  end

endmodule

// File: tb/tb_sinc_n_decimator.sv
// Bench for sinc_n_decimator: three configurations share en/osr/rst, and a
// direct-form CIC model feeds a per-instance scoreboard of value and arrival cycle.
module tb_sinc_n_decimator;

  typedef struct {
    longint val;
    int     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [5:0]  osr = 6'd32;
  logic        inA = 1'b0;
  logic [15:0] inB = '0;
  logic [15:0] inC = '0;
  logic [16:0] outA;
  logic [30:0] outB;
  logic [40:0] outC;
  logic        vldA, vldB, vldC;

  int     cyc = 0;
  int     tests = 0;
  int     fails = 0;
  longint lastOut [3];
  exp_t   sb      [3][$];
  longint hist    [3][$];
  longint sHist   [3][$];
  int     mCount;
  int     mOsrEff;
  bit     mArmed;

  localparam longint SENTINEL = 64'h7FFF_FFFF_FFFF_FFFF;

  sinc_n_decimator #(.ORDER(3), .IN_WIDTH(1), .SIGNED_IN(0), .MAX_OSR(32)) uA (
    .clk(clk), .rst(rst), .en(en), .in(inA), .osr(osr), .out(outA), .outValid(vldA));
  sinc_n_decimator #(.ORDER(3), .IN_WIDTH(16), .SIGNED_IN(1), .MAX_OSR(32)) uB (
    .clk(clk), .rst(rst), .en(en), .in(inB), .osr(osr), .out(outB), .outValid(vldB));
  sinc_n_decimator #(.ORDER(5), .IN_WIDTH(16), .SIGNED_IN(1), .MAX_OSR(32)) uC (
    .clk(clk), .rst(rst), .en(en), .in(inC), .osr(osr), .out(outC), .outValid(vldC));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ordOf(input int i);
    return (i == 2) ? 5 : 3;
  endfunction

  function automatic int widthOf(input int i);
    case (i)
      0:       return 17;
      1:       return 31;
      default: return 41;
    endcase
  endfunction

  function automatic longint dutOut(input int i);
    case (i)
      0:       return longint'($signed(outA));
      1:       return longint'($signed(outB));
      default: return longint'($signed(outC));
    endcase
  endfunction

  function automatic bit dutVld(input int i);
    case (i)
      0:       return vldA;
      1:       return vldB;
      default: return vldC;
    endcase
  endfunction

  function automatic longint xOf(input int i);
    case (i)
      0:       return longint'(inA);
      1:       return longint'($signed(inB));
      default: return longint'($signed(inC));
    endcase
  endfunction

  function automatic int clampOsr(input int v);
    if (v == 0) return 1;
    if (v > 32) return 32;
    return v;
  endfunction

  function automatic longint binom(input longint n, input int k);
    longint r = 1;
    if (n < 0 || n < longint'(k)) return 0;
    for (int t = 0; t < k; t++) r = r * (n - t) / (t + 1);
    return r;
  endfunction

  function automatic longint sext(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic modelClear();
    for (int i = 0; i < 3; i++) begin
      sb[i].delete();
      hist[i].delete();
      sHist[i].delete();
    end
    mCount = 0;
    mArmed = 1'b0;
  endtask

  // Integrator output in closed form: I_N(n) = sum x_j * C(n-1-j, N-1); the
  // combs are an N-th backward difference across window samples.
  task automatic modelStep();
    bit     strobe;
    int     n, k, nOrd;
    longint s, y;
    exp_t   e;
    if (!mArmed) begin
      mOsrEff = clampOsr(int'(osr));
      mArmed  = 1'b1;
    end
    if (en) begin
      strobe = (mCount == mOsrEff - 1);
      for (int i = 0; i < 3; i++) begin
        nOrd = ordOf(i);
        if (strobe) begin
          n = hist[i].size();
          s = 0;
          for (int j = 0; j < n; j++) s += hist[i][j] * binom(longint'(n - 1 - j), nOrd - 1);
          sHist[i].push_back(s);
          k = sHist[i].size();
          y = 0;
          for (int t = 0; t <= nOrd; t++) begin
            if (k - 1 - t >= 0) begin
              if (t % 2 == 1) y -= binom(longint'(nOrd), t) * sHist[i][k-1-t];
              else            y += binom(longint'(nOrd), t) * sHist[i][k-1-t];
            end
          end
          e.val = sext(y, widthOf(i));
          e.cyc = cyc + 1;
          sb[i].push_back(e);
        end
        hist[i].push_back(xOf(i));
      end
      if (strobe) begin
        mCount  = 0;
        mOsrEff = clampOsr(int'(osr));
      end else begin
        mCount++;
      end
    end
  endtask

  task automatic cycle(input bit e, input bit a, input logic [15:0] b, input logic [15:0] c);
    en  = e;
    inA = a;
    inB = b;
    inC = c;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int osrVal);
    rst = 1'b1;
    en  = 1'b0;
    inA = 1'b0;
    inB = '0;
    inC = '0;
    osr = 6'(osrVal);
    modelClear();
    for (int i = 0; i < 3; i++) lastOut[i] = SENTINEL;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int i = 0; i < 3; i++) begin
          if (dutVld(i)) begin
            tests++;
            if (sb[i].size() == 0) begin
              fails++;
              $display("[TB] FAIL unexpected_valid dut%0d: got outValid with out=%0d at cycle %0d, required no strobe",
                       i, dutOut(i), cyc);
            end else begin
              e = sb[i].pop_front();
              if (e.cyc !== cyc || e.val !== dutOut(i)) begin
                fails++;
                $display("[TB] FAIL scoreboard dut%0d: got out=%0d at cycle %0d, required out=%0d at cycle %0d",
                         i, dutOut(i), cyc, e.val, e.cyc);
              end
            end
            lastOut[i] = dutOut(i);
          end else if (sb[i].size() > 0 && sb[i][0].cyc <= cyc) begin
            tests++;
            fails++;
            $display("[TB] FAIL missed_valid dut%0d: got outValid=0 at cycle %0d, required out=%0d at cycle %0d",
                     i, cyc, sb[i][0].val, sb[i][0].cyc);
            void'(sb[i].pop_front());
          end
        end
      end
    end
  endtask

  task automatic checkLast(input int i, input longint req, input string name);
    tests++;
    if (lastOut[i] !== req) begin
      fails++;
      $display("[TB] FAIL %s dut%0d: got out=%0d, required %0d", name, i, lastOut[i], req);
    end
  endtask

  task automatic test_reset();
    doReset(8);
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b1, 16'd100, 16'd100);
    rst = 1'b1;
    modelClear();
    #1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (dutOut(i) !== 0 || dutVld(i) !== 1'b0) begin
        fails++;
        $display("[TB] FAIL reset_state dut%0d: got out=%0d outValid=%0b, required 0/0", i, dutOut(i), dutVld(i));
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_dc_osr32();
    doReset(32);
    for (int k = 0; k < 8 * 32 + 2; k++) cycle(1'b1, 1'b1, 16'd1000, 16'h8000);
    checkLast(0, 64'sd32768, "dc_unsigned_osr32");
    checkLast(1, 64'sd32768000, "dc_signed_osr32");
    checkLast(2, -(64'sd1 <<< 40), "dc_order5_fullscale");
  endtask

  task automatic test_signed_osr4();
    doReset(4);
    for (int k = 0; k < 42; k++) cycle(1'b1, 1'b0, 16'd1000, 16'd0);
    checkLast(0, 64'sd0, "zero_input");
    checkLast(1, 64'sd64000, "signed_pos_osr4");
    checkLast(2, 64'sd0, "zero_input_order5");
    for (int k = 0; k < 42; k++) cycle(1'b1, 1'b1, -16'sd1000, 16'd1);
    checkLast(0, 64'sd64, "unsigned_osr4");
    checkLast(1, -64'sd64000, "signed_neg_osr4");
    checkLast(2, 64'sd1024, "order5_osr4");
  endtask

  task automatic test_en_toggle();
    int prev = -1;
    int nV = 0;
    doReset(5);
    for (int k = 0; k < 60; k++) begin
      cycle((k % 2) == 0, 1'b1, 16'd7, 16'd7);
      if (vldA) begin
        if (prev >= 0) begin
          tests++;
          if (cyc - prev != 10) begin
            fails++;
            $display("[TB] FAIL en_toggle_period: got %0d clks, required 10", cyc - prev);
          end
        end
        prev = cyc;
        nV++;
      end
    end
    tests++;
    if (nV != 6) begin
      fails++;
      $display("[TB] FAIL en_toggle_count: got %0d strobes, required 6", nV);
    end
  endtask

  task automatic test_osr_clamp();
    int nV = 0;
    int first = -1;
    int second = -1;
    doReset(0);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b1, 16'd3, 16'd3);
      if (vldA) nV++;
    end
    tests++;
    if (nV != 6) begin
      fails++;
      $display("[TB] FAIL osr0_back_to_back: got %0d strobes in 6 clks, required 6", nV);
    end
    doReset(40);
    nV = 0;
    for (int k = 0; k < 70; k++) begin
      cycle(1'b1, 1'b1, 16'd3, 16'd3);
      if (vldA) begin
        if (first < 0) first = cyc;
        else second = cyc;
        nV++;
      end
    end
    tests++;
    if (nV != 2 || second - first != 32) begin
      fails++;
      $display("[TB] FAIL osr40_clamp: got %0d strobes spaced %0d, required 2 spaced 32", nV, second - first);
    end
  endtask

  task automatic test_osr_change();
    int idx[$];
    doReset(8);
    for (int k = 0; k < 51; k++) cycle(1'b1, 1'b1, 16'd1, 16'd1);
    checkLast(0, 64'sd512, "osr8_steady");
    checkLast(1, 64'sd512, "osr8_steady_signed");
    osr = 6'd4;
    for (int k = 1; k <= 60; k++) begin
      cycle(1'b1, 1'b1, 16'd1, 16'd1);
      if (vldA) idx.push_back(k);
    end
    tests++;
    if (idx.size() < 2 || idx[0] != 5 || idx[1] != 9) begin
      fails++;
      $display("[TB] FAIL osr_change_boundary: got first strobes at %0d,%0d, required 5,9",
               (idx.size() > 0) ? idx[0] : -1, (idx.size() > 1) ? idx[1] : -1);
    end
    checkLast(0, 64'sd64, "osr4_steady");
    checkLast(1, 64'sd64, "osr4_steady_signed");
  endtask

  task automatic test_reset_midwindow();
    int n = 0;
    doReset(8);
    for (int k = 0; k < 19; k++) cycle(1'b1, 1'b1, 16'd5, 16'd5);
    rst = 1'b1;
    modelClear();
    #1;
    tests++;
    if (outA !== '0 || vldA !== 1'b0) begin
      fails++;
      $display("[TB] FAIL async_reset_mid: got out=%0d outValid=%0b, required 0/0", outA, vldA);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    while (n < 20) begin
      cycle(1'b1, 1'b1, 16'd5, 16'd5);
      n++;
      if (vldA) break;
    end
    tests++;
    if (n != 8 || vldA !== 1'b1) begin
      fails++;
      $display("[TB] FAIL first_window_after_reset: got outValid after %0d clks, required 8", n);
    end
    rst = 1'b1;
    modelClear();
    #1;
    tests++;
    if (vldA !== 1'b0 || vldB !== 1'b0 || vldC !== 1'b0) begin
      fails++;
      $display("[TB] FAIL pending_valid_suppressed: got outValid=%0b%0b%0b, required 000", vldA, vldB, vldC);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 16'd5, 16'd5);
  endtask

  initial begin
    modelClear();
    for (int i = 0; i < 3; i++) lastOut[i] = SENTINEL;
    fork
      monitor();
    join_none
    test_reset();
    test_dc_osr32();
    test_signed_osr4();
    test_en_toggle();
    test_osr_clamp();
    test_osr_change();
    test_reset_midwindow();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
